fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8, width of one FIFO read-data entry (byte).
REQ-002 Parameter PACK, default 4, number of entries packed per output word; legal range 2..8.
REQ-003 Parameter FLUSH_TMO, default 16, idle cycles before a partial word is flushed (used only with PACKER_FLUSH_EN).
REQ-004 clk_i  input  1  single clock; same clock as the upstream FIFO's read clock.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 fifo_empty_i  input  1  FIFO empty flag.
REQ-007 fifo_rdata_i  input  IN_WIDTH  FIFO read data, valid the cycle after fifo_rd_en_o is sampled.
REQ-008 fifo_rd_error_i  input  1  FIFO read-underflow flag, sampled alongside fifo_rdata_i.
REQ-009 fifo_rd_en_o  output  1  FIFO read request.
REQ-010 m_valid_o  output  1  packed word valid.
REQ-011 m_ready_i  input  1  downstream ready.
REQ-012 m_data_o  output  IN_WIDTH*PACK  packed word, entry 0 in bits [IN_WIDTH-1:0] (little-endian lanes).
REQ-013 m_keep_o  output  PACK  per-lane valid mask.
REQ-014 word_cnt_o  output  16  count of accepted output words, wraps at 2^16.

Function
REQ-015 State machine has two states: FILL (collecting entries) and HOLD (presenting a word).
REQ-016 fifo_rd_en_o is combinational: 1 iff state==FILL, fifo_empty_i==0, and byte_cnt+pend < PACK.
REQ-017 pend is a register equal to fifo_rd_en_o delayed one cycle; at most one read is in flight.
REQ-018 In a cycle with pend==1 and fifo_rd_error_i==0, fifo_rdata_i is written into lane byte_cnt and byte_cnt increments at the clock edge.
REQ-019 In a cycle with pend==1 and fifo_rd_error_i==1, the data is discarded and byte_cnt is unchanged.
REQ-020 When a capture makes byte_cnt==PACK, the state moves to HOLD at the same edge, with m_valid_o=1 and m_keep_o all ones.
REQ-021 Latency: fifo_rd_en_o high in cycle N gives a capture at the end of cycle N+1; if that capture fills the word, m_valid_o is high from cycle N+2.
REQ-022 In HOLD, m_data_o and m_keep_o stay stable and fifo_rd_en_o stays 0 until m_valid_o and m_ready_i are both high at a clock edge.
REQ-023 On that handshake: byte_cnt clears, lanes clear to 0, m_valid_o goes 0, word_cnt_o increments, and the state returns to FILL; the next read may issue in the following cycle.
REQ-024 Back-to-back reads are permitted: while fifo_empty_i stays low in FILL, one entry is captured per cycle after the first.
REQ-025 Unfilled lanes of m_data_o are 0.

Reset
REQ-026 While rst_n_i==0, and immediately on its assertion: state=FILL, byte_cnt=0, pend=0, lanes=0, idle counter=0, m_valid_o=0, m_data_o=0, m_keep_o=0, word_cnt_o=0; fifo_rd_en_o is 0.
REQ-027 On reset mid-operation, partially collected entries and any in-flight read are discarded, and FIFO data read but not captured is lost.
REQ-028 Reset deassertion is synchronised to clk_i inside the block; the first read may issue no earlier than the second edge after deassertion.

Configuration
REQ-029 Macro PACKER_FLUSH_EN, when defined, adds a 16-bit idle counter.
REQ-030 With PACKER_FLUSH_EN, the idle counter increments in FILL whenever byte_cnt>0, pend==0, and fifo_rd_en_o==0.
REQ-031 With PACKER_FLUSH_EN, the idle counter clears on any capture or on leaving FILL.
REQ-032 With PACKER_FLUSH_EN, when the idle counter reaches FLUSH_TMO the state moves to HOLD with m_keep_o bit i=1 for i<byte_cnt.
REQ-033 Without PACKER_FLUSH_EN, the counter is absent, partial words wait indefinitely, and m_keep_o is all ones whenever m_valid_o=1.

Verification
REQ-034 8 entries 0x11..0x88 preloaded, m_ready_i=1 -> words 0x44332211 then 0x88776655, m_keep_o=0xF, word_cnt_o=2.
REQ-035 First word in HOLD with m_ready_i=0 for 20 cycles -> m_data_o stable at 0x44332211, fifo_rd_en_o=0 throughout, and no entry lost after release.
REQ-036 One entry written every 5 cycles (empty toggling) -> fifo_rd_en_o only asserts while fifo_empty_i=0, and the word is assembled in arrival order.
REQ-037 fifo_rd_error_i=1 on the second capture of 0xAA,(err),0xBB,0xCC,0xDD -> word 0xDDCCBBAA.
REQ-038 rst_n_i pulsed low after 2 captures -> all outputs 0; the next 4 entries 0x01..0x04 give 0x04030201.
REQ-039 With PACKER_FLUSH_EN and FLUSH_TMO=16, 3 entries 0x01..0x03 then FIFO empty -> m_valid_o 16 idle cycles later with m_data_o=0x00030201 and m_keep_o=0x7.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs PACK FIFO read entries into one wide output word.
// Optional partial-word flush on idle timeout when PACKER_FLUSH_EN is defined.
module fifo_rd_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int PACK      = 4,
    parameter int FLUSH_TMO = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     fifo_empty_i,
    input  logic [IN_WIDTH-1:0]      fifo_rdata_i,
    input  logic                     fifo_rd_error_i,
    output logic                     fifo_rd_en_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [IN_WIDTH*PACK-1:0] m_data_o,
    output logic [PACK-1:0]          m_keep_o,
    output logic [15:0]              word_cnt_o
);
    localparam int CNT_W = $clog2(PACK + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           byte_cnt_q, byte_cnt_d;
    logic                       pend_q, pend_d;
    logic [IN_WIDTH*PACK-1:0]   lanes_q, lanes_d;
    logic [PACK-1:0]            keep_q, keep_d;
    logic [15:0]                word_cnt_q, word_cnt_d;
    logic [1:0]                 rst_sync_q, rst_sync_d;
    logic [CNT_W:0]             inflight;
    logic                       rd_en;
    logic                       capture;
`ifdef PACKER_FLUSH_EN
    logic [15:0]                idle_q, idle_d;
`else
    localparam int flush_tmo_unused = FLUSH_TMO;
`endif

    // Reads are held off until the synchronised reset release reaches stage 2.
    assign inflight     = {1'b0, byte_cnt_q} + {{CNT_W{1'b0}}, pend_q};
    assign rd_en        = rst_sync_q[1] && (state_q == FILL) && !fifo_empty_i
                          && (inflight < (CNT_W+1)'(PACK));
    assign capture      = pend_q && !fifo_rd_error_i;
    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = (state_q == HOLD);
    assign m_data_o     = lanes_q;
    assign m_keep_o     = keep_q;
    assign word_cnt_o   = word_cnt_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pend_d     = rd_en;
        lanes_d    = lanes_q;
        keep_d     = keep_q;
        word_cnt_d = word_cnt_q;
        rst_sync_d = {rst_sync_q[0], 1'b1};
`ifdef PACKER_FLUSH_EN
        idle_d     = idle_q;
`endif
        case (state_q)
            FILL: begin
                if (capture) begin
                    lanes_d[int'(byte_cnt_q)*IN_WIDTH +: IN_WIDTH] = fifo_rdata_i;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == CNT_W'(PACK - 1)) begin
                        state_d = HOLD;
                        keep_d  = '1;
                    end
                end
`ifdef PACKER_FLUSH_EN
                if (capture) begin
                    idle_d = '0;
                end else if ((byte_cnt_q != '0) && !pend_q && !rd_en) begin
                    idle_d = idle_q + 16'd1;
                    // Flush at the edge where the counter would reach the timeout.
                    if (idle_q + 16'd1 == 16'(FLUSH_TMO)) begin
                        state_d = HOLD;
                        idle_d  = '0;
                        for (int i = 0; i < PACK; i++) begin
                            keep_d[i] = (int'(byte_cnt_q) > i);
                        end
                    end
                end
`endif
            end
            HOLD: begin
                if (m_ready_i) begin
                    state_d    = FILL;
                    byte_cnt_d = '0;
                    lanes_d    = '0;
                    keep_d     = '0;
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= FILL;
            byte_cnt_q <= '0;
            pend_q     <= 1'b0;
            lanes_q    <= '0;
            keep_q     <= '0;
            word_cnt_q <= '0;
            rst_sync_q <= '0;
`ifdef PACKER_FLUSH_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pend_q     <= pend_d;
            lanes_q    <= lanes_d;
            keep_q     <= keep_d;
            word_cnt_q <= word_cnt_d;
            rst_sync_q <= rst_sync_d;
`ifdef PACKER_FLUSH_EN
            idle_q     <= idle_d;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - self-checking bench for fifo_rd_packer with a FIFO and word model.
module tb_fifo_rd_packer;
    localparam int W = 8;
    localparam int P = 4;

    logic           clk = 1'b0;
    logic           rst_n_i;
    logic           fifo_empty_i;
    logic [W-1:0]   fifo_rdata_i;
    logic           fifo_rd_error_i;
    logic           fifo_rd_en_o;
    logic           m_valid_o;
    logic           m_ready_i;
    logic [W*P-1:0] m_data_o;
    logic [P-1:0]   m_keep_o;
    logic [15:0]    word_cnt_o;

    always #5 clk = ~clk;

    fifo_rd_packer dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rdata_i(fifo_rdata_i), .fifo_rd_error_i(fifo_rd_error_i),
        .fifo_rd_en_o(fifo_rd_en_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_keep_o(m_keep_o), .word_cnt_o(word_cnt_o)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [8:0]     fifo_q[$];
    logic [W-1:0]   part[$];
    logic [W*P-1:0] exp_data[$];
    logic [P-1:0]   exp_keep[$];
    logic [W*P-1:0] dut_log[$];
    int             model_cnt = 0;
    logic           deliv = 1'b0;
    logic           deliv_err = 1'b0;
    logic [W-1:0]   deliv_data = '0;
    logic           rd_req = 1'b0;
    logic           hold_prev = 1'b0;
    logic [W*P-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment FIFO plus the word-level model and per-cycle compare.
    initial begin
        fifo_rdata_i    = '0;
        fifo_rd_error_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n_i) begin
                check("word_cnt", 64'(word_cnt_o), 64'(16'(model_cnt)));
                if (fifo_empty_i || m_valid_o)
                    check("rd_en_blocked", 64'(fifo_rd_en_o), 64'd0);
                if (hold_prev && m_valid_o)
                    check("hold_stable", 64'(m_data_o), 64'(prev_data));
                if (m_valid_o && m_ready_i) begin
                    if (exp_data.size() == 0) begin
                        check("unexpected_word", 64'(m_data_o), 64'hDEAD_0000_0000);
                    end else begin
                        check("word_data", 64'(m_data_o), 64'(exp_data.pop_front()));
                        check("word_keep", 64'(m_keep_o), 64'(exp_keep.pop_front()));
                    end
                    dut_log.push_back(m_data_o);
                    model_cnt++;
                end
                if (deliv && !deliv_err) begin
                    part.push_back(deliv_data);
                    if (part.size() == P) begin
                        logic [W*P-1:0] w;
                        w = '0;
                        for (int i = 0; i < P; i++) w[i*W +: W] = part[i];
                        exp_data.push_back(w);
                        exp_keep.push_back('1);
                        part.delete();
                    end
                end
            end
            hold_prev = rst_n_i && m_valid_o && !m_ready_i;
            prev_data = m_data_o;
            rd_req    = fifo_rd_en_o;
            @(posedge clk);
            #1;
            deliv = 1'b0;
            fifo_rd_error_i = 1'b0;
            if (rd_req) begin
                if (fifo_q.size() == 0) begin
                    check("read_from_empty", 64'd1, 64'd0);
                end else begin
                    logic [8:0] e;
                    e = fifo_q.pop_front();
                    fifo_rdata_i    = e[7:0];
                    fifo_rd_error_i = e[8];
                    deliv      = 1'b1;
                    deliv_err  = e[8];
                    deliv_data = e[7:0];
                end
            end
            fifo_empty_i = (fifo_q.size() == 0);
        end
    end

    task automatic push(input logic [8:0] e);
        fifo_q.push_back(e);
        fifo_empty_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && part.size() == 0 && exp_data.size() == 0
                 && !m_valid_o && !deliv) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= 300) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, 64'(m_valid_o), 64'd0);
        check({name, "_data"},  64'(m_data_o),  64'd0);
        check({name, "_keep"},  64'(m_keep_o),  64'd0);
        check({name, "_cnt"},   64'(word_cnt_o), 64'd0);
        check({name, "_rd_en"}, 64'(fifo_rd_en_o), 64'd0);
    endtask

    initial begin
        int n;
        rst_n_i      = 1'b0;
        fifo_empty_i = 1'b1;
        m_ready_i    = 1'b1;
        #12;
        check_outputs_zero("reset");
        @(posedge clk); #3;
        rst_n_i = 1'b1;
        repeat (3) @(posedge clk);

        // 8 preloaded entries, ready high; also first-word latency.
        #2;
        for (int i = 1; i <= 8; i++) push({1'b0, 8'(i * 8'h11)});
        n = 0;
        while (!fifo_rd_en_o && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("first_rd_timeout", 64'd1, 64'd0);
        n = 0;
        while (!m_valid_o && n < 50) begin @(negedge clk); n++; end
        check("latency", 64'(n), 64'd5);
        wait_idle("t1");
        check("t1_w0", 64'(dut_log[0]), 64'h44332211);
        check("t1_w1", 64'(dut_log[1]), 64'h88776655);
        check("t1_cnt", 64'(word_cnt_o), 64'd2);

        // Back-pressure: hold the first word for 20 cycles.
        @(posedge clk); #2;
        m_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) push({1'b0, 8'(8'h20 + i)});
        n = 0;
        while (!m_valid_o && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_hold_data", 64'(m_data_o), 64'h24232221);
            check("t2_hold_rd_en", 64'(fifo_rd_en_o), 64'd0);
        end
        @(posedge clk); #2;
        m_ready_i = 1'b1;
        wait_idle("t2");
        check("t2_w0", 64'(dut_log[2]), 64'h24232221);
        check("t2_w1", 64'(dut_log[3]), 64'h28272625);

        // One entry every 5 cycles.
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #2;
            push({1'b0, 8'(8'h30 + i)});
            repeat (4) @(posedge clk);
        end
        wait_idle("t3");
        check("t3_w", 64'(dut_log[4]), 64'h34333231);

        // Underflow error on the second read is discarded.
        @(posedge clk); #2;
        push(9'h0AA); push(9'h1EE); push(9'h0BB); push(9'h0CC); push(9'h0DD);
        wait_idle("t4");
        check("t4_w", 64'(dut_log[5]), 64'hDDCCBBAA);

        // Reset after two captures; partial word is discarded.
        @(posedge clk); #2;
        push(9'h051); push(9'h052);
        n = 0;
        while (part.size() < 2 && n < 50) begin @(posedge clk); #2; n++; end
        @(posedge clk); #3;
        rst_n_i = 1'b0;
        part.delete();
        model_cnt = 0;
        #1;
        check_outputs_zero("midreset");
        @(posedge clk); #2;
        for (int i = 1; i <= 4; i++) push({1'b0, 8'(i)});
        @(posedge clk); #3;
        rst_n_i = 1'b1;
        @(negedge clk);
        check("sync_gap0", 64'(fifo_rd_en_o), 64'd0);
        @(negedge clk);
        check("sync_gap1", 64'(fifo_rd_en_o), 64'd0);
        @(negedge clk);
        check("sync_first_rd", 64'(fifo_rd_en_o), 64'd1);
        wait_idle("t5");
        check("t5_w", 64'(dut_log[dut_log.size()-1]), 64'h04030201);
        check("t5_cnt", 64'(word_cnt_o), 64'd1);

`ifdef PACKER_FLUSH_EN
        // Partial word flushed after 16 idle cycles.
        @(posedge clk); #2;
        m_ready_i = 1'b0;
        push(9'h001); push(9'h002); push(9'h003);
        n = 0;
        while (part.size() < 3 && n < 50) begin @(posedge clk); #2; n++; end
        n = 0;
        while (!m_valid_o && n < 60) begin @(negedge clk); n++; end
        check("flush_delay", 64'(n), 64'd17);
        check("flush_data", 64'(m_data_o), 64'h00030201);
        check("flush_keep", 64'(m_keep_o), 64'h7);
        exp_data.push_back(32'h00030201);
        exp_keep.push_back(4'h7);
        part.delete();
        @(posedge clk); #2;
        m_ready_i = 1'b1;
        wait_idle("t6");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
